// File: rtl/cbx_param_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbx_param_cfg_if
//  Purpose  : Bundles the configuration-chain and routing-channel signals of
//             one X-direction connection block.
//  Ports    : master - drives ccff_en/ccff_head/ccff_commit and the incoming
//                      channel tracks, observes all block outputs.
//             slave  - the connection block itself.
//  Revision : 1.0  initial release
// ============================================================================
interface cbx_param_cfg_if #(
    parameter int CHAN_W   = 9,
    parameter int NUM_IPIN = 6
);
    logic                ccff_en;
    logic                ccff_head;
    logic                ccff_commit;
    logic [CHAN_W-1:0]   chanx_left_in;
    logic [CHAN_W-1:0]   chanx_right_in;
    logic [CHAN_W-1:0]   chanx_left_out;
    logic [CHAN_W-1:0]   chanx_right_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_tail;
    logic                cfg_loaded;
    logic                cfg_err;

    modport master (
        output ccff_en, ccff_head, ccff_commit, chanx_left_in, chanx_right_in,
        input  chanx_left_out, chanx_right_out, ipin_out, ccff_tail,
               cfg_loaded, cfg_err
    );

    modport slave (
        input  ccff_en, ccff_head, ccff_commit, chanx_left_in, chanx_right_in,
        output chanx_left_out, chanx_right_out, ipin_out, ccff_tail,
               cfg_loaded, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/cbx_param_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : cbx_param_cfg
//  Purpose  : Parametrised X-direction connection block. Channel tracks pass
//             straight through left<->right; each grid input pin is driven by
//             a MUX_SIZE:1 tap mux. Configuration shifts into a shadow chain
//             and is copied to the live configuration only on a commit that
//             follows exactly CHAIN_LEN shifts.
//  Ports    : prog_clk - only clock, rising edge
//             pReset   - synchronous active-high reset
//             bus      - cbx_param_cfg_if.slave (config chain, channels,
//                        ipin_out, ccff_tail, cfg_loaded, cfg_err)
//  Revision : 1.0  initial release
// ============================================================================
module cbx_param_cfg #(
    parameter int CHAN_W   = 9,
    parameter int NUM_IPIN = 6,
    parameter int MUX_SIZE = 6,   // even, >= 2
    parameter int STRIDE   = 4
) (
    input  logic           prog_clk,
    input  logic           pReset,
    cbx_param_cfg_if.slave bus
);
    localparam int c_sel_w     = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
    localparam int c_chain_len = NUM_IPIN * c_sel_w;
    localparam int c_cnt_w     = $clog2(c_chain_len + 2);
    localparam int c_tap_n     = 1 << c_sel_w;

    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_chain_len);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Load-progress state: IDLE (cnt=0), SHIFTING (0<cnt<=CHAIN_LEN),
    // OVERRUN (cnt saturated at CHAIN_LEN+1).
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_shifting = 2'd1;
    localparam logic [1:0] c_st_overrun  = 2'd2;

    logic [c_chain_len-1:0] r_shadow;
    logic [c_chain_len-1:0] r_active;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [1:0]             r_state;
    logic                   r_loaded;
    logic                   r_err;

    wire  [c_chain_len:0]   w_shadow_next;
    wire  [NUM_IPIN-1:0]    w_ipin;

    // Prepend the new head bit; the top bit falls off the chain.
    assign w_shadow_next = {r_shadow, bus.ccff_head};

    // ------------------------------------------------------------------------
    // Shadow chain, shift counter and commit handling. Commit outranks shift,
    // reset outranks both.
    // ------------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_state  <= c_st_idle;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else if (bus.ccff_commit) begin
            r_cnt   <= '0;
            r_state <= c_st_idle;
            if (r_cnt == c_cnt_full) begin
                r_active <= r_shadow;
                r_loaded <= 1'b1;
                r_err    <= 1'b0;
            end else begin
                r_err    <= 1'b1;
            end
        end else if (bus.ccff_en) begin
            r_shadow <= w_shadow_next[c_chain_len-1:0];
            // Counter sticks at CHAIN_LEN+1 so any over-long load is rejected.
            if (r_state != c_st_overrun) begin
                r_cnt   <= r_cnt + c_cnt_one;
                r_state <= (r_cnt == c_cnt_full) ? c_st_overrun : c_st_shifting;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tap muxes. The tap vector is padded to a power of two with zeros so an
    // out-of-range select reads a constant 0 instead of an undefined bit.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
        wire [c_tap_n-1:0] w_taps;
        wire [c_sel_w-1:0] w_sel;

        assign w_sel = r_active[i*c_sel_w +: c_sel_w];

        for (genvar j = 0; j < c_tap_n; j++) begin : g_tap
            if (j < MUX_SIZE) begin : g_live
                localparam int c_t = (i + (j / 2) * STRIDE) % CHAN_W;
                if ((j % 2) == 0) begin : g_left
                    assign w_taps[j] = bus.chanx_left_in[c_t];
                end else begin : g_right
                    assign w_taps[j] = bus.chanx_right_in[c_t];
                end
            end else begin : g_pad
                assign w_taps[j] = 1'b0;
            end
        end

        assign w_ipin[i] = r_loaded & w_taps[w_sel];
    end

    // Feedthrough shorts are pure wires, independent of reset and config.
    assign bus.chanx_left_out  = bus.chanx_right_in;
    assign bus.chanx_right_out = bus.chanx_left_in;

    assign bus.ipin_out   = w_ipin;
    assign bus.ccff_tail  = r_shadow[c_chain_len-1];
    assign bus.cfg_loaded = r_loaded;
    assign bus.cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cbx_param_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbx_param_cfg
//  Purpose  : Self-checking bench for cbx_param_cfg. A default-parameter
//             instance is checked every cycle against a behavioural model;
//             a small-parameter instance is checked with literal vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cbx_param_cfg;
    localparam int CW = 9;
    localparam int NI = 6;
    localparam int MS = 6;
    localparam int ST = 4;
    localparam int SW = 3;
    localparam int CL = NI * SW;

    logic prog_clk;
    logic pReset;

    int n_checks = 0;
    int n_errors = 0;

    cbx_param_cfg_if #(.CHAN_W(CW), .NUM_IPIN(NI)) if0 ();
    cbx_param_cfg_if #(.CHAN_W(4),  .NUM_IPIN(3))  if1 ();

    cbx_param_cfg #(.CHAN_W(CW), .NUM_IPIN(NI), .MUX_SIZE(MS), .STRIDE(ST)) u_dut0 (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (if0.slave)
    );

    cbx_param_cfg #(.CHAN_W(4), .NUM_IPIN(3), .MUX_SIZE(2), .STRIDE(1)) u_dut1 (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (if1.slave)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model of the default instance: a history of shifted bits,
    // a plain integer shift count and per-pin select values.
    // ------------------------------------------------------------------------
    bit m_hist[$];
    int m_cnt;
    bit m_loaded;
    bit m_err;
    int m_sel[NI];
    bit m_valid = 1'b0;

    // Shadow bit p holds the bit shifted in p shifts ago.
    function automatic bit m_s(input int p);
        if (p < m_hist.size()) return m_hist[m_hist.size() - 1 - p];
        return 1'b0;
    endfunction

    function automatic logic [NI-1:0] exp_ipin(input logic [CW-1:0] l, input logic [CW-1:0] r);
        logic [NI-1:0] v;
        v = '0;
        for (int i = 0; i < NI; i++) begin
            int s;
            int t;
            s = m_sel[i];
            t = (i + (s / 2) * ST) % CW;
            if (m_loaded && s < MS) v[i] = (s % 2 == 1) ? r[t] : l[t];
        end
        return v;
    endfunction

    always @(posedge prog_clk) begin
        if (pReset) begin
            m_valid  = 1'b1;
            m_hist.delete();
            m_cnt    = 0;
            m_loaded = 1'b0;
            m_err    = 1'b0;
            for (int i = 0; i < NI; i++) m_sel[i] = 0;
        end else if (if0.ccff_commit) begin
            if (m_cnt == CL) begin
                for (int i = 0; i < NI; i++) begin
                    int s;
                    s = 0;
                    for (int b = 0; b < SW; b++) if (m_s(i * SW + b)) s += (1 << b);
                    m_sel[i] = s;
                end
                m_loaded = 1'b1;
                m_err    = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end else if (if0.ccff_en) begin
            m_hist.push_back(if0.ccff_head);
            if (m_hist.size() > CL) void'(m_hist.pop_front());
            if (m_cnt < CL + 1) m_cnt++;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge prog_clk) begin
        chk("ft_right0", {23'd0, if0.chanx_right_out}, {23'd0, if0.chanx_left_in});
        chk("ft_left0",  {23'd0, if0.chanx_left_out},  {23'd0, if0.chanx_right_in});
        chk("ft_right1", {28'd0, if1.chanx_right_out}, {28'd0, if1.chanx_left_in});
        chk("ft_left1",  {28'd0, if1.chanx_left_out},  {28'd0, if1.chanx_right_in});
        if (m_valid) begin
            chk("ipin",   {26'd0, if0.ipin_out},
                          {26'd0, exp_ipin(if0.chanx_left_in, if0.chanx_right_in)});
            chk("tail",   {31'd0, if0.ccff_tail},  {31'd0, m_s(CL - 1)});
            chk("loaded", {31'd0, if0.cfg_loaded}, {31'd0, m_loaded});
            chk("err",    {31'd0, if0.cfg_err},    {31'd0, m_err});
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic rand_chan();
        if0.chanx_left_in  = CW'($urandom);
        if0.chanx_right_in = CW'($urandom);
        if1.chanx_left_in  = 4'($urandom);
        if1.chanx_right_in = 4'($urandom);
    endtask

    // Shift bits[n-1] first so that after n shifts bits[k] sits in S[k].
    task automatic shift_n(input logic [31:0] bits, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            if0.ccff_en   = 1'b1;
            if0.ccff_head = bits[b];
            tick();
        end
        if0.ccff_en   = 1'b0;
        if0.ccff_head = 1'b0;
    endtask

    task automatic commit0();
        if0.ccff_commit = 1'b1;
        tick();
        if0.ccff_commit = 1'b0;
    endtask

    function automatic logic [31:0] pack(input int s0, input int s1, input int s2,
                                         input int s3, input int s4, input int s5);
        logic [31:0] v;
        v = 32'(s0 & 7) | (32'(s1 & 7) << 3) | (32'(s2 & 7) << 6) |
            (32'(s3 & 7) << 9) | (32'(s4 & 7) << 12) | (32'(s5 & 7) << 15);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pReset = 1'b1;
        if0.ccff_en = 1'b0; if0.ccff_head = 1'b0; if0.ccff_commit = 1'b0;
        if1.ccff_en = 1'b0; if1.ccff_head = 1'b0; if1.ccff_commit = 1'b0;
        rand_chan();

        // Reset defaults
        tick();
        rand_chan();
        tick();
        pReset = 1'b0;
        @(negedge prog_clk);
        chk("rst_ipin",   {26'd0, if0.ipin_out}, 32'd0);
        chk("rst_loaded", {31'd0, if0.cfg_loaded}, 32'd0);
        chk("rst_err",    {31'd0, if0.cfg_err}, 32'd0);
        chk("rst_tail",   {31'd0, if0.ccff_tail}, 32'd0);
        chk("rst_ipin1",  {29'd0, if1.ipin_out}, 32'd0);

        // All selects zero: ipin_out[i] follows chanx_left_in[i]
        tick();
        shift_n(32'd0, CL);
        commit0();
        @(negedge prog_clk);
        chk("zero_loaded", {31'd0, if0.cfg_loaded}, 32'd1);
        for (int r = 0; r < 3; r++) begin
            rand_chan();
            #1;
            chk("zero_ipin", {26'd0, if0.ipin_out}, {26'd0, if0.chanx_left_in[5:0]});
        end

        // ipin0 sel=5: k=2, t=8, odd tap -> right track 8
        tick();
        shift_n(pack(5, 0, 0, 0, 0, 0), CL);
        commit0();
        @(negedge prog_clk);
        for (int r = 0; r < 3; r++) begin
            rand_chan();
            #1;
            chk("sel5_ipin0", {31'd0, if0.ipin_out[0]}, {31'd0, if0.chanx_right_in[8]});
        end

        // Out-of-range selects drive 0
        tick();
        shift_n(pack(6, 7, 6, 7, 6, 7), CL);
        commit0();
        @(negedge prog_clk);
        for (int r = 0; r < 3; r++) begin
            rand_chan();
            #1;
            chk("oor_ipin", {26'd0, if0.ipin_out}, 32'd0);
        end

        // Known routing: ipin0 sel=1 -> right track 0
        tick();
        shift_n(pack(1, 2, 3, 4, 5, 0), CL);
        commit0();
        @(negedge prog_clk);
        chk("ref_ipin0", {31'd0, if0.ipin_out[0]}, {31'd0, if0.chanx_right_in[0]});

        // Length check: 17 shifts rejected, routing kept
        tick();
        shift_n(pack(0, 0, 0, 0, 0, 0), CL - 1);
        commit0();
        @(negedge prog_clk);
        chk("short_err",  {31'd0, if0.cfg_err}, 32'd1);
        chk("short_keep", {31'd0, if0.ipin_out[0]}, {31'd0, if0.chanx_right_in[0]});

        // 19 shifts rejected
        tick();
        shift_n(32'd0, CL + 1);
        commit0();
        @(negedge prog_clk);
        chk("long_err",  {31'd0, if0.cfg_err}, 32'd1);
        chk("long_keep", {31'd0, if0.ipin_out[0]}, {31'd0, if0.chanx_right_in[0]});

        // Exactly 18 shifts accepted, then back-to-back commit rejected
        tick();
        shift_n(pack(0, 1, 0, 0, 0, 0), CL);
        commit0();
        commit0();
        @(negedge prog_clk);
        chk("b2b_err",    {31'd0, if0.cfg_err}, 32'd1);
        chk("b2b_loaded", {31'd0, if0.cfg_loaded}, 32'd1);
        chk("b2b_ipin0",  {31'd0, if0.ipin_out[0]}, {31'd0, if0.chanx_left_in[0]});
        chk("b2b_ipin1",  {31'd0, if0.ipin_out[1]}, {31'd0, if0.chanx_right_in[1]});

        // Chain pass-through: single 1 reaches tail after exactly 18 shifts
        tick();
        shift_n(32'd0, CL);
        shift_n(32'h1_0000, CL - 1);
        @(negedge prog_clk);
        chk("tail_17", {31'd0, if0.ccff_tail}, 32'd0);
        tick();
        shift_n(32'd0, 1);
        @(negedge prog_clk);
        chk("tail_18", {31'd0, if0.ccff_tail}, 32'd1);

        // Shift enable during commit is ignored (count is in overrun here)
        tick();
        if0.ccff_en = 1'b1;
        if0.ccff_head = 1'b0;
        commit0();
        if0.ccff_en = 1'b0;
        @(negedge prog_clk);
        chk("coll_tail", {31'd0, if0.ccff_tail}, 32'd1);
        chk("coll_err",  {31'd0, if0.cfg_err}, 32'd1);

        // Reset at shift 9 discards the partial load
        tick();
        shift_n(32'h1FF, 9);
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        @(negedge prog_clk);
        chk("mid_loaded", {31'd0, if0.cfg_loaded}, 32'd0);
        chk("mid_tail",   {31'd0, if0.ccff_tail}, 32'd0);
        tick();
        shift_n(32'hFFFF, CL - 9);
        commit0();
        @(negedge prog_clk);
        chk("mid_err", {31'd0, if0.cfg_err}, 32'd1);
        tick();
        shift_n(32'h3FFFF, CL);
        @(negedge prog_clk);
        chk("mid_tail_full", {31'd0, if0.ccff_tail}, 32'd1);
        tick();
        commit0();
        @(negedge prog_clk);
        chk("mid_ok_err", {31'd0, if0.cfg_err}, 32'd0);
        chk("mid_oor",    {26'd0, if0.ipin_out}, 32'd0);

        // Small instance: CHAIN_LEN=3, sel=1 on ipin2 -> right track 2
        tick();
        for (int b = 2; b >= 0; b--) begin
            if1.ccff_en   = 1'b1;
            if1.ccff_head = (b == 2);
            tick();
        end
        if1.ccff_en   = 1'b0;
        if1.ccff_head = 1'b0;
        if1.ccff_commit = 1'b1;
        tick();
        if1.ccff_commit = 1'b0;
        @(negedge prog_clk);
        chk("sw_err",    {31'd0, if1.cfg_err}, 32'd0);
        chk("sw_loaded", {31'd0, if1.cfg_loaded}, 32'd1);
        for (int r = 0; r < 3; r++) begin
            rand_chan();
            #1;
            chk("sw_ipin2", {31'd0, if1.ipin_out[2]}, {31'd0, if1.chanx_right_in[2]});
            chk("sw_ipin10", {30'd0, if1.ipin_out[1:0]}, {30'd0, if1.chanx_left_in[1:0]});
        end

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cbx_param_cfg.md
# cbx_param_cfg

Parametrised X-direction connection block with a double-buffered configuration chain. Tracks pass straight through between the left and right channel ports. Each of NUM_IPIN grid input pins is driven by a MUX_SIZE:1 tap mux. Configuration shifts into a shadow chain on prog_clk and takes effect only on an explicit, length-checked commit, so a partial or over-long load never corrupts the live routing.

## Interface
Parameters:
- CHAN_W, 9: tracks per direction.
- NUM_IPIN, 6: grid input pins driven by this block.
- MUX_SIZE, 6: inputs per ipin mux. Must be even and ≥2.
- STRIDE, 4: track spacing between consecutive taps of one mux.
- Derived SEL_W = clog2(MUX_SIZE): 3 by default, 1 when MUX_SIZE=2.
- Derived CHAIN_LEN = NUM_IPIN*SEL_W: 18 by default.

Ports:
- prog_clk  in  1  the only clock; all state is on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- ccff_en  in  1  shift enable for the configuration chain.
- ccff_head  in  1  serial configuration data in.
- ccff_commit  in  1  single-cycle strobe that copies the shadow chain to the active configuration.
- chanx_left_in  in  CHAN_W  tracks arriving from the left.
- chanx_right_in  in  CHAN_W  tracks arriving from the right.
- chanx_left_out  out  CHAN_W  equals chanx_right_in; combinational.
- chanx_right_out  out  CHAN_W  equals chanx_left_in; combinational.
- ipin_out  out  NUM_IPIN  grid pin drivers; combinational from the active configuration.
- ccff_tail  out  1  serial data out, equal to S[CHAIN_LEN-1].
- cfg_loaded  out  1  a valid configuration has been committed since reset.
- cfg_err  out  1  the last commit was rejected.

## Operation
Shadow chain S[CHAIN_LEN-1:0]:
- On ccff_en=1 and ccff_commit=0: S <= {S[CHAIN_LEN-2:0], ccff_head}.
- ccff_tail is registered: it is S[CHAIN_LEN-1].

Shift counter cnt, width clog2(CHAIN_LEN+2):
- +1 per accepted shift.
- Saturates at CHAIN_LEN+1, which means overrun.

Commit (ccff_commit=1):
- If cnt==CHAIN_LEN: A <= S, cfg_loaded <= 1, cfg_err <= 0.
- Otherwise (underrun or overrun): A unchanged, cfg_loaded unchanged, cfg_err <= 1.
- In both cases: cnt <= 0 and S is kept.
- ccff_en is ignored in the commit cycle, so commit has priority over shift.

Mux selection:
- sel_i = A[i*SEL_W +: SEL_W].
- Tap j of ipin i, with k = j/2 and t = (i + k*STRIDE) mod CHAN_W:
  - j even: chanx_left_in[t].
  - j odd: chanx_right_in[t].
- ipin_out[i] is tap sel_i.
- ipin_out[i] is 0 when sel_i ≥ MUX_SIZE.
- All ipin_out are 0 while cfg_loaded=0.

Feedthrough:
- The left/right shorts are independent of all configuration state and of reset.

State machine:
- IDLE: cnt=0.
- SHIFTING: 0<cnt≤CHAIN_LEN.
- OVERRUN: cnt=CHAIN_LEN+1.
- Any commit or pReset returns to IDLE.

## Timing
- Reset values: S=0, A=0, cnt=0, cfg_loaded=0, cfg_err=0, ccff_tail=0, ipin_out=0.
- Feedthrough is unaffected by reset.
- pReset has priority over ccff_en and ccff_commit in the same cycle.
- pReset mid-shift discards the partial load; a later commit then needs a full CHAIN_LEN shifts.
- ccff_tail follows ccff_head with a latency of CHAIN_LEN shifts, so chained blocks form one daisy chain.
- A commit at edge n changes ipin_out after edge n; the new routing is visible in cycle n+1.
- ipin_out reacts combinationally to channel inputs within a cycle.
- Back-to-back commits:
  - The second sees cnt=0 and is rejected (cfg_err=1).
  - A is retained and cfg_loaded stays at its previous value.
- Deasserted ccff_en holds S and cnt.
- cfg_err clears only on a successful commit or on pReset.

## Test plan
- Reset defaults: drive channels with random values; apply pReset -> ipin_out=0, cfg_loaded=0, cfg_err=0, ccff_tail=0; chanx_right_out==chanx_left_in and chanx_left_out==chanx_right_in every cycle.
- Full load, default params, all sel=0: shift 18 zeros, then commit -> cfg_loaded=1 in the next cycle; ipin_out[i]==chanx_left_in[i]. Then load ipin0 sel=5 and commit -> ipin_out[0]==chanx_right_in[8] (k=2, t=8).
- Out-of-range select: load sel=6 or sel=7 on every pin, then commit -> all ipin_out=0 regardless of channel values.
- Length check:
  - 17 shifts then commit -> cfg_err=1 and A unchanged.
  - 19 shifts then commit -> cfg_err=1.
  - Exactly 18 shifts then commit -> cfg_err=0.
  - A commit in the very next cycle -> cfg_err=1 and the previous routing is kept.
- Chain pass-through and collisions: shift 1 followed by 17 zeros -> ccff_tail=1 after exactly 18 shifts. ccff_en=1 together with ccff_commit -> S unshifted. pReset at shift 9 -> cnt=0 and S=0.
- Parameter sweep: CHAN_W=4, NUM_IPIN=3, MUX_SIZE=2, STRIDE=1 -> CHAIN_LEN=3. sel=1 on ipin2 -> ipin_out[2]==chanx_right_in[2]; a commit after 3 shifts is accepted.
